// File: rtl/sine_width_dds.sv
// Phase-accumulator DDS feeding a quarter-wave sine table; emits one PWM duty width per period tick.
// Optional build macro SINE_AMP_SCALE_EN adds an 8-bit amplitude input and one extra pipeline stage.
module sine_width_dds #(
  parameter int PERIOD  = 1000,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int AMP_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
`ifdef SINE_AMP_SCALE_EN
  input  logic [7:0]         amp,
`endif
  output logic [31:0]        width,
  output logic               width_valid,
  output logic               cycle_start
);

  localparam logic [31:0] HALF = 32'(PERIOD / 2);

  // round((2^AMP_W-1)*sin(pi/2*(k+0.5)/2^LUT_AW)), tabulated for LUT_AW=6, AMP_W=10
  localparam logic [AMP_W-1:0] SINE_LUT [2**LUT_AW] = '{
    10'd13,   10'd38,   10'd63,   10'd88,   10'd113,  10'd138,  10'd163,  10'd187,
    10'd212,  10'd236,  10'd261,  10'd285,  10'd309,  10'd333,  10'd356,  10'd380,
    10'd403,  10'd426,  10'd449,  10'd471,  10'd493,  10'd515,  10'd537,  10'd558,
    10'd579,  10'd599,  10'd619,  10'd639,  10'd659,  10'd678,  10'd696,  10'd714,
    10'd732,  10'd750,  10'd766,  10'd783,  10'd799,  10'd814,  10'd829,  10'd844,
    10'd858,  10'd871,  10'd884,  10'd896,  10'd908,  10'd919,  10'd930,  10'd940,
    10'd950,  10'd959,  10'd967,  10'd975,  10'd983,  10'd989,  10'd995,  10'd1001,
    10'd1006, 10'd1010, 10'd1014, 10'd1017, 10'd1019, 10'd1021, 10'd1022, 10'd1023
  };

  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W-1:0]  pending;
  logic [PHASE_W:0]    sum;
  logic                wrapped;
  logic [LUT_AW+1:0]   p1;
  logic                v1, v2, v3;
  logic                cs1, cs2, cs3;
  logic                sign2, sign3;
  logic [LUT_AW-1:0]   a2;
  logic [AMP_W-1:0]    m3;
  logic                v_last, cs_last, sign_last;
  logic [AMP_W-1:0]    mag;
  logic [31:0]         prod;
  logic [31:0]         s_off;
  logic [31:0]         width_next;

`ifdef SINE_AMP_SCALE_EN
  logic                v4, cs4, sign4;
  logic [AMP_W-1:0]    m4;
  assign v_last    = v4;
  assign cs_last   = cs4;
  assign sign_last = sign4;
  assign mag       = m4;
`else
  assign v_last    = v3;
  assign cs_last   = cs3;
  assign sign_last = sign3;
  assign mag       = m3;
`endif

  // the pending word is the increment applied at a tick; a coincident load lands for the next tick
  assign sum        = {1'b0, acc} + {1'b0, pending};
  assign prod       = 32'(mag) * HALF;
  assign s_off      = prod >> AMP_W;
  assign width_next = sign_last ? (HALF - s_off) : (HALF + s_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      pending     <= '0;
      wrapped     <= 1'b0;
      p1          <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      cs1         <= 1'b0;
      cs2         <= 1'b0;
      cs3         <= 1'b0;
      sign2       <= 1'b0;
      sign3       <= 1'b0;
      a2          <= '0;
      m3          <= '0;
`ifdef SINE_AMP_SCALE_EN
      v4          <= 1'b0;
      cs4         <= 1'b0;
      sign4       <= 1'b0;
      m4          <= '0;
`endif
      width       <= HALF;
      width_valid <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (freq_load) pending <= freq_word;

      if (tick) begin
        acc     <= sum[PHASE_W-1:0];
        wrapped <= sum[PHASE_W];
        p1      <= acc[PHASE_W-1 -: LUT_AW+2];
        cs1     <= wrapped | (acc == '0);
      end
      v1 <= tick;

      // odd quadrants walk the quarter-wave table backwards
      v2    <= v1;
      cs2   <= cs1;
      sign2 <= p1[LUT_AW+1];
      a2    <= p1[LUT_AW] ? ~p1[LUT_AW-1:0] : p1[LUT_AW-1:0];

      v3    <= v2;
      cs3   <= cs2;
      sign3 <= sign2;
      m3    <= SINE_LUT[a2];

`ifdef SINE_AMP_SCALE_EN
      v4    <= v3;
      cs4   <= cs3;
      sign4 <= sign3;
      m4    <= AMP_W'(({8'd0, m3} * {{AMP_W{1'b0}}, amp}) >> 8);
`endif

      width_valid <= v_last;
      cycle_start <= v_last & cs_last;
      if (v_last) width <= width_next;
    end
  end

endmodule

// File: tb/tb_sine_width_dds.sv
// Self-checking bench for sine_width_dds: directed sequence plus random frequency/tick traffic
// compared cycle by cycle against a real-valued sine reference model.
module tb_sine_width_dds;

  localparam int PERIOD  = 1000;
  localparam int PHASE_W = 16;
  localparam int LUT_AW  = 6;
  localparam int AMP_W   = 10;
  localparam int HALF    = PERIOD / 2;
`ifdef SINE_AMP_SCALE_EN
  localparam int LAT   = 4;
  localparam int AMPV  = 128;
  localparam int EXP1  = 502;
  localparam int EXP17 = 749;
  localparam int EXP49 = 251;
`else
  localparam int LAT   = 3;
  localparam int EXP1  = 506;
  localparam int EXP17 = 999;
  localparam int EXP49 = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                tick = 1'b0;
  logic                freq_load = 1'b0;
  logic [PHASE_W-1:0]  freq_word = '0;
  logic [31:0]         width;
  logic                width_valid;
  logic                cycle_start;
`ifdef SINE_AMP_SCALE_EN
  logic [7:0]          amp = 8'(AMPV);
`endif

  sine_width_dds #(
    .PERIOD (PERIOD),
    .PHASE_W(PHASE_W),
    .LUT_AW (LUT_AW),
    .AMP_W  (AMP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .freq_word  (freq_word),
    .freq_load  (freq_load),
`ifdef SINE_AMP_SCALE_EN
    .amp        (amp),
`endif
    .width      (width),
    .width_valid(width_valid),
    .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int w;
    bit cs;
  } exp_t;

  exp_t        pend_q[$];
  int unsigned m_acc = 0;
  int unsigned m_pend = 0;
  bit          m_wr = 1'b0;
  int          cur_w = HALF;
  int          cyc = 0;
  int          n_samples = 0;
  int          n_pulses = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int lut_model(int k);
    real x;
    x = 3.14159265358979 * (real'(k) + 0.5) / (2.0 * real'(2 ** LUT_AW));
    return int'($floor(real'(2 ** AMP_W - 1) * $sin(x) + 0.5));
  endfunction

  function automatic int model_width(int unsigned p);
    int q, i, a, m, s;
    q = int'(p >> (PHASE_W - 2));
    i = int'((p >> (PHASE_W - 2 - LUT_AW)) % (2 ** LUT_AW));
    a = (q % 2 == 1) ? (2 ** LUT_AW - 1 - i) : i;
    m = lut_model(a);
`ifdef SINE_AMP_SCALE_EN
    m = (m * AMPV) / 256;
`endif
    s = (m * HALF) / (2 ** AMP_W);
    return (q >= 2) ? HALF - s : HALF + s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // drive one clock of stimulus, advance the model, then compare outputs just after the edge
  task automatic cycle(input bit t, input bit fl, input logic [PHASE_W-1:0] fw);
    int unsigned sum;
    exp_t        e;
    bit          exp_v;
    bit          exp_cs;
    exp_v  = 1'b0;
    exp_cs = 1'b0;
    tick      = t;
    freq_load = fl;
    freq_word = fw;
    @(posedge clk);
    cyc++;
    if (t) begin
      e.due = cyc + LAT;
      e.w   = model_width(m_acc);
      e.cs  = m_wr || (m_acc == 0);
      pend_q.push_back(e);
      sum   = m_acc + m_pend;
      m_wr  = (sum >= 2 ** PHASE_W);
      m_acc = sum % (2 ** PHASE_W);
    end
    if (fl) m_pend = int'(fw);
    #1;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      e      = pend_q.pop_front();
      cur_w  = e.w;
      exp_v  = 1'b1;
      exp_cs = e.cs;
      n_samples++;
      if (n_samples == 1) begin
        check("first_width", width, 32'(EXP1));
        check("first_cycle_start", 32'(cycle_start), 32'd1);
      end
      if (n_samples == 17) check("quarter_peak_width", width, 32'(EXP17));
      if (n_samples == 49) check("three_quarter_trough_width", width, 32'(EXP49));
    end
    if (width_valid === 1'b1) n_pulses++;
    check("width", width, 32'(cur_w));
    check("width_valid", 32'(width_valid), 32'(exp_v));
    check("cycle_start", 32'(cycle_start), 32'(exp_cs));
    tick      = 1'b0;
    freq_load = 1'b0;
  endtask

  initial begin
    int p0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_width", width, 32'(HALF));
    check("reset_valid", 32'(width_valid), 32'd0);
    check("reset_cycle_start", 32'(cycle_start), 32'd0);
    rst_n = 1'b1;

    cycle(1'b0, 1'b1, 16'h0400);
    repeat (49) begin
      cycle(1'b1, 1'b0, '0);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, '0);
    end
    repeat (LAT + 1) cycle(1'b0, 1'b0, '0);

    p0 = n_pulses;
    repeat (8) cycle(1'b1, 1'b0, '0);
    repeat (LAT + 1) cycle(1'b0, 1'b0, '0);
    check("burst_pulse_count", 32'(n_pulses - p0), 32'd8);

    cycle(1'b1, 1'b1, 16'h0800);
    repeat (3) cycle(1'b1, 1'b0, '0);
    repeat (LAT + 2) cycle(1'b0, 1'b0, '0);

    repeat (300) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 16'($urandom));
    repeat (LAT + 1) cycle(1'b0, 1'b0, '0);

    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("midreset_width", width, 32'(HALF));
    check("midreset_valid", 32'(width_valid), 32'd0);
    check("midreset_cycle_start", 32'(cycle_start), 32'd0);
    pend_q.delete();
    m_acc  = 0;
    m_pend = 0;
    m_wr   = 1'b0;
    cur_w  = HALF;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    rst_n = 1'b1;
    p0 = n_pulses;
    repeat (LAT + 4) cycle(1'b0, 1'b0, '0);
    check("no_stale_pulses", 32'(n_pulses - p0), 32'd0);

    cycle(1'b0, 1'b1, 16'h1234);
    repeat (20) cycle(1'b1, 1'b0, '0);
    repeat (LAT + 1) cycle(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
